// File: rtl/shared_mem_port.sv
// Requester-side port between one SIMD core and the shared scratchpad arbiter.
// Accepts a single-beat or burst command, requests the bus, issues consecutive word addresses and returns read data.
module shared_mem_port #(
    parameter int BUS_SIZE = 128,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_we,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [LEN_W-1:0]    i_cmd_len,
    input  logic                i_wvalid,
    input  logic [BUS_SIZE-1:0] i_wdata,
    output logic                o_wready,
    output logic                o_rvalid,
    output logic [BUS_SIZE-1:0] o_rdata,
    output logic                o_rlast,
    output logic                o_done,
    output logic                o_req,
    input  logic                i_grant,
    output logic                o_en,
    output logic                o_we,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [BUS_SIZE-1:0] o_data,
    input  logic [BUS_SIZE-1:0] i_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic                we_q;
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    count;
    logic                rvalid_q;
    logic                rlast_q;

    logic                issue;
    logic                last_beat;

    // A write beat needs the core's data in the same cycle the grant is held.
    assign issue     = (state == BUSY) && i_grant && (!we_q || i_wvalid);
    assign last_beat = (count == len_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            count    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            rvalid_q <= issue && !we_q;
            rlast_q  <= issue && !we_q && last_beat;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        we_q   <= i_cmd_we;
                        base_q <= i_cmd_addr;
                        len_q  <= i_cmd_len;
                        count  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (issue) begin
                        count <= count + LEN_W'(1);
                        if (last_beat) begin
                            state <= we_q ? IDLE : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = (state == IDLE);
    assign o_req       = (state == BUSY);
    assign o_en        = issue;
    assign o_we        = issue && we_q;
    assign o_wready    = issue && we_q;
    // Address arithmetic wraps naturally at the top of the word space.
    assign o_addr      = issue ? (base_q + ADDR_W'(count)) : '0;
    assign o_data      = (issue && we_q) ? i_wdata : '0;

    // Read data from the scratchpad arrives one cycle after the beat, aligned with rvalid.
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rvalid_q ? i_data : '0;
    assign o_rlast     = rlast_q;
    assign o_done      = (issue && we_q && last_beat) || (state == DRAIN);

endmodule

// File: tb/tb_shared_mem_port.sv
// Directed self-checking bench for shared_mem_port with a small scratchpad model behind the bus.
module tb_shared_mem_port;

    localparam int BUS_SIZE = 128;
    localparam int ADDR_W   = 10;
    localparam int LEN_W    = 4;
    localparam logic [127:0] WPAT1 = {16{8'hA5}};

    logic                clk;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic                wvalid;
    logic [BUS_SIZE-1:0] wdata;
    logic                wready;
    logic                rvalid;
    logic [BUS_SIZE-1:0] rdata;
    logic                rlast;
    logic                done;
    logic                req;
    logic                grant;
    logic                en;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [BUS_SIZE-1:0] data_out;
    logic [BUS_SIZE-1:0] data_in;

    logic [BUS_SIZE-1:0] mem [0:1023];

    int errors;
    int checks;
    int beat;

    shared_mem_port #(
        .BUS_SIZE(BUS_SIZE),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_we   (cmd_we),
        .i_cmd_addr (cmd_addr),
        .i_cmd_len  (cmd_len),
        .i_wvalid   (wvalid),
        .i_wdata    (wdata),
        .o_wready   (wready),
        .o_rvalid   (rvalid),
        .o_rdata    (rdata),
        .o_rlast    (rlast),
        .o_done     (done),
        .o_req      (req),
        .i_grant    (grant),
        .o_en       (en),
        .o_we       (we),
        .o_addr     (addr),
        .o_data     (data_out),
        .i_data     (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad model: writes land on the beat edge, reads return one cycle later.
    always @(posedge clk) begin
        if (en && we) mem[addr] <= data_out;
        if (en && !we) data_in <= mem[addr];
    end

    function automatic logic [127:0] rpat(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {96'hFACE0000CAFE0000BEEF0000, 22'd0, a10};
    endfunction

    function automatic logic [127:0] wpat(input int k);
        logic [7:0] b;
        b = 8'h30 + k[7:0];
        return {16{b}};
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wvalid    = 1'b0;
        wdata     = '0;
        grant     = 1'b0;
        data_in   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = rpat(i);

        // Reset state
        #3;
        check_output("rst_cmd_ready", cmd_ready, 1);
        check_output("rst_req", req, 0);
        check_output("rst_en", en, 0);
        check_output("rst_we", we, 0);
        check_output("rst_rvalid", rvalid, 0);
        check_output("rst_done", done, 0);
        check_output("rst_addr", addr, 0);
        check_output("rst_data", data_out, 0);
        check_output("rst_rdata", rdata, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Single write with immediate grant
        cyc();
        grant = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h010; cmd_len = 4'd0;
        wvalid = 1'b1; wdata = WPAT1;
        #1;
        check_output("w1_accept_ready", cmd_ready, 1);
        check_output("w1_accept_req", req, 0);
        check_output("w1_accept_en", en, 0);
        cyc();
        cmd_valid = 1'b0;
        #1;
        check_output("w1_req", req, 1);
        check_output("w1_en", en, 1);
        check_output("w1_we", we, 1);
        check_output("w1_addr", addr, 10'h010);
        check_output("w1_data", data_out, WPAT1);
        check_output("w1_wready", wready, 1);
        check_output("w1_done", done, 1);
        check_output("w1_cmd_ready_busy", cmd_ready, 0);
        cyc();
        wvalid = 1'b0;
        #1;
        check_output("w1_req_after", req, 0);
        check_output("w1_en_after", en, 0);
        check_output("w1_done_after", done, 0);
        check_output("w1_ready_after", cmd_ready, 1);
        check_output("w1_mem", mem[10'h010], WPAT1);

        // Read burst wrapping the address space, grant delayed three cycles
        grant = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h3FE; cmd_len = 4'd3;
        #1;
        check_output("r2_accept_ready", cmd_ready, 1);
        for (int c = 0; c < 3; c++) begin
            cyc();
            cmd_valid = 1'b0;
            #1;
            check_output("r2_wait_req", req, 1);
            check_output("r2_wait_en", en, 0);
            check_output("r2_wait_we", we, 0);
        end
        cyc();
        grant = 1'b1;
        #1;
        check_output("r2_b0_en", en, 1);
        check_output("r2_b0_we", we, 0);
        check_output("r2_b0_addr", addr, 10'h3FE);
        check_output("r2_b0_rvalid", rvalid, 0);
        cyc();
        #1;
        check_output("r2_b1_addr", addr, 10'h3FF);
        check_output("r2_b1_rvalid", rvalid, 1);
        check_output("r2_b1_rdata", rdata, rpat(10'h3FE));
        check_output("r2_b1_rlast", rlast, 0);
        cyc();
        #1;
        check_output("r2_b2_addr", addr, 10'h000);
        check_output("r2_b2_rdata", rdata, rpat(10'h3FF));
        cyc();
        #1;
        check_output("r2_b3_en", en, 1);
        check_output("r2_b3_addr", addr, 10'h001);
        check_output("r2_b3_req", req, 1);
        check_output("r2_b3_rdata", rdata, rpat(10'h000));
        check_output("r2_b3_done", done, 0);
        cyc();
        #1;
        check_output("r2_drain_req", req, 0);
        check_output("r2_drain_en", en, 0);
        check_output("r2_drain_rvalid", rvalid, 1);
        check_output("r2_drain_rdata", rdata, rpat(10'h001));
        check_output("r2_drain_rlast", rlast, 1);
        check_output("r2_drain_done", done, 1);
        check_output("r2_drain_ready", cmd_ready, 0);
        cyc();
        #1;
        check_output("r2_idle_rvalid", rvalid, 0);
        check_output("r2_idle_rlast", rlast, 0);
        check_output("r2_idle_done", done, 0);
        check_output("r2_idle_ready", cmd_ready, 1);

        // Write burst of 8 with grant withdrawn for two cycles after beat 2
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h100; cmd_len = 4'd7;
        beat = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            cmd_valid = 1'b0;
            grant = !(c == 3 || c == 4);
            wvalid = 1'b1;
            wdata = wpat(beat);
            #1;
            check_output("w3_req", req, 1);
            check_output("w3_en", en, grant);
            check_output("w3_wready", wready, grant);
            if (grant) begin
                check_output("w3_addr", addr, 10'(10'h100 + beat));
                check_output("w3_data", data_out, wpat(beat));
                check_output("w3_done", done, (beat == 7));
                beat++;
            end
        end
        cyc();
        wvalid = 1'b0;
        grant = 1'b1;
        #1;
        check_output("w3_beats", beat, 8);
        check_output("w3_req_after", req, 0);
        check_output("w3_en_after", en, 0);
        check_output("w3_mem0", mem[10'h100], wpat(0));
        check_output("w3_mem3", mem[10'h103], wpat(3));
        check_output("w3_mem7", mem[10'h107], wpat(7));
        check_output("w3_mem8_untouched", mem[10'h108], rpat(10'h108));

        // Write stall: wvalid low for two cycles after beat 0
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h200; cmd_len = 4'd2;
        beat = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            cmd_valid = 1'b0;
            wvalid = !(c == 1 || c == 2);
            wdata = wpat(8'h40 + beat);
            #1;
            check_output("w4_req", req, 1);
            check_output("w4_en", en, wvalid);
            if (wvalid) begin
                check_output("w4_addr", addr, 10'(10'h200 + beat));
                check_output("w4_done", done, (beat == 2));
                beat++;
            end else begin
                check_output("w4_stall_wready", wready, 0);
            end
        end
        cyc();
        wvalid = 1'b0;
        #1;
        check_output("w4_req_after", req, 0);
        check_output("w4_mem0", mem[10'h200], wpat(8'h40));
        check_output("w4_mem1", mem[10'h201], wpat(8'h41));
        check_output("w4_mem2", mem[10'h202], wpat(8'h42));

        // Asynchronous reset in the middle of a read burst
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h020; cmd_len = 4'd5;
        for (int c = 0; c < 3; c++) begin
            cyc();
            cmd_valid = 1'b0;
            #1;
            check_output("r5_addr", addr, 10'(10'h020 + c));
        end
        cyc();
        #1;
        check_output("r5_pre_en", en, 1);
        check_output("r5_pre_rvalid", rvalid, 1);
        check_output("r5_pre_rdata", rdata, rpat(10'h022));
        #1;
        rst_n = 1'b0;
        #1;
        check_output("r5_rst_req", req, 0);
        check_output("r5_rst_en", en, 0);
        check_output("r5_rst_rvalid", rvalid, 0);
        check_output("r5_rst_done", done, 0);
        check_output("r5_rst_ready", cmd_ready, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check_output("r5_rel_ready", cmd_ready, 1);
        check_output("r5_rel_done", done, 0);
        cyc();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010; cmd_len = 4'd0;
        cyc();
        cmd_valid = 1'b0;
        #1;
        check_output("r5_next_en", en, 1);
        check_output("r5_next_addr", addr, 10'h010);
        cyc();
        #1;
        check_output("r5_next_rdata", rdata, WPAT1);
        check_output("r5_next_rlast", rlast, 1);
        check_output("r5_next_done", done, 1);

        // Back-to-back reads with cmd_valid held high
        cyc();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h040; cmd_len = 4'd1;
        #1;
        check_output("b6_accept1", cmd_ready, 1);
        cyc();
        cmd_addr = 10'h080;
        #1;
        check_output("b6_a_b0_ready", cmd_ready, 0);
        check_output("b6_a_b0_addr", addr, 10'h040);
        cyc();
        #1;
        check_output("b6_a_b1_addr", addr, 10'h041);
        check_output("b6_a_b1_rdata", rdata, rpat(10'h040));
        cyc();
        #1;
        check_output("b6_a_drain_done", done, 1);
        check_output("b6_a_drain_ready", cmd_ready, 0);
        check_output("b6_a_drain_rdata", rdata, rpat(10'h041));
        cyc();
        #1;
        check_output("b6_accept2", cmd_ready, 1);
        check_output("b6_accept2_done", done, 0);
        cyc();
        cmd_valid = 1'b0;
        #1;
        check_output("b6_b_b0_addr", addr, 10'h080);
        cyc();
        #1;
        check_output("b6_b_b1_addr", addr, 10'h081);
        check_output("b6_b_b1_rdata", rdata, rpat(10'h080));
        cyc();
        #1;
        check_output("b6_b_drain_done", done, 1);
        check_output("b6_b_drain_rlast", rlast, 1);
        check_output("b6_b_drain_rdata", rdata, rpat(10'h081));
        cyc();
        #1;
        check_output("b6_idle_ready", cmd_ready, 1);
        check_output("b6_idle_req", req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_mem_port.md
Name: shared_mem_port

Overview:
Requester-side port between one SIMD core and the shared scratchpad arbiter: one instance per core, with its `o_req` and `i_grant` wired to one bit of the arbiter's request/grant vectors. It accepts a single-beat or burst read/write command from the core. It then raises a request, waits for grant, issues consecutive word addresses on the shared bus, and returns read data to the core. It is the initiator counterpart of the shared memory/arbiter block.

Parameters:
- BUS_SIZE, 128, data width of one beat (one scratchpad word).
- ADDR_W, 10, word address width; the address space is 2^ADDR_W words.
- LEN_W, 4, width of the burst length field; a burst is 1..2^LEN_W beats.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_cmd_valid  input  1  core command valid.
- o_cmd_ready  output  1  port idle; command accepted when valid&ready.
- i_cmd_we  input  1  1=write burst, 0=read burst.
- i_cmd_addr  input  ADDR_W  base word address.
- i_cmd_len  input  LEN_W  beats minus 1.
- i_wvalid  input  1  core write beat valid.
- i_wdata  input  BUS_SIZE  core write beat data.
- o_wready  output  1  write beat consumed this cycle.
- o_rvalid  output  1  read beat valid (no backpressure).
- o_rdata  output  BUS_SIZE  read beat data.
- o_rlast  output  1  marks last read beat.
- o_done  output  1  one-cycle pulse when the command completes.
- o_req  output  1  request to arbiter.
- i_grant  input  1  grant from arbiter.
- o_en  output  1  bus beat strobe to scratchpad.
- o_we  output  1  write enable qualifying o_en.
- o_addr  output  ADDR_W  bus word address.
- o_data  output  BUS_SIZE  bus write data.
- i_data  input  BUS_SIZE  bus read data, valid 1 cycle after a read o_en.

Behaviour:
- Reset is asynchronous and active-low. On i_rstn=0 the port enters IDLE immediately.
  - o_req, o_en, o_we, o_wready, o_rvalid, o_rlast and o_done are 0; o_cmd_ready is 1 after reset.
  - o_addr, o_data and o_rdata are 0.
  - The beat counter and latched command are cleared.
- Reset mid-burst aborts the burst: no further beats and no o_done. Partial writes already performed stand.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid, latch we, addr, len; clear beat count; next state BUSY.
  - Commands are not accepted in any other state.
- BUSY:
  - o_req=1 for the whole state.
  - A beat issues in a cycle when i_grant=1 and (read, or i_wvalid=1).
  - On an issued beat, o_en=1 combinationally. o_we=latched we, o_addr=base+count (mod 2^ADDR_W, wraps to 0), o_data=i_wdata.
  - For writes, o_wready equals the issue condition, so the core beat is consumed in the same cycle.
  - Count increments on each issued beat.
  - If i_grant drops mid-burst, issuing pauses with o_req held and resumes when grant returns. No beat is lost or duplicated.
  - A write with i_wvalid=0 while granted stalls without a beat and keeps holding grant.
  - On the issue of beat count==len:
    - Write: next state IDLE and o_done pulses in that same cycle.
    - Read: next state DRAIN.
- DRAIN (reads only):
  - o_req=0.
  - Lasts one cycle to capture the final beat; next state IDLE.
  - o_done pulses in the DRAIN cycle, coincident with the last o_rvalid.
- Read return:
  - o_rvalid is a registered copy of (o_en & ~o_we), giving a latency of exactly one cycle after the beat.
  - o_rdata=i_data in that cycle.
  - o_rlast=1 on the rvalid of beat len.
  - Beats are returned in address order.
- o_req falls in the cycle after the last beat issues (BUSY→IDLE/DRAIN). It never toggles within a burst.
- A new command is accepted no earlier than the cycle after o_done.
- Minimum burst cost with grant already available: write of N beats = 1 accept cycle + N cycles; read adds 1 DRAIN cycle.
- o_en never asserts without i_grant=1. o_we=0 whenever o_en=0.

Test Plan:
- Single write, immediate grant: cmd we=1, addr=0x010, len=0, i_wvalid=1, wdata=0xA5.. → one o_en cycle with addr 0x010, data 0xA5..; o_done same cycle; o_req high exactly 1 cycle.
- Read burst, grant delayed 3 cycles: we=0, addr=0x3FE, len=3 → o_req held 3 idle cycles; beats at addresses 0x3FE, 0x3FF, 0x000, 0x001; o_rvalid 1 cycle after each; o_rlast and o_done on the 4th.
- Grant withdrawn mid-burst: write len=7, i_grant low during beats 3-4 for 2 cycles → exactly 8 o_en pulses at consecutive addresses; o_req continuously high; no duplicate o_wready.
- Write stall: write len=2 with i_wvalid low for 2 cycles after beat 0 → no o_en during the stall; 3 total beats with correct data order.
- Async reset mid read burst (after beat 2 of len=5) → o_req, o_en and o_rvalid drop immediately without a clock; no o_done; o_cmd_ready=1 after release; next command runs normally.
- Back-to-back commands: i_cmd_valid held high with 2 reads of len=1 → second accepted only after the first o_done; address sequences correct.
